// File: rtl/set_injector_seq.sv
// rtl/set_injector_seq.sv - per-channel delayed SET/PULSE/RELEASE value injector
// Each channel runs its own IDLE/WAIT/PULSE sequencer; ABORT is always accepted.
module set_injector_seq #(
  parameter int                   SET_SIZE      = 5,
  parameter int                   SET_WIDTH     = 16,
  parameter int                   DLY_WIDTH     = 16,
  parameter logic [SET_WIDTH-1:0] DEFAULT_VALUE = '0,
  localparam int                  CW            = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_cmd_valid,
  output logic                          o_cmd_ready,
  input  logic [CW-1:0]                 i_cmd_chan,
  input  logic [1:0]                    i_cmd_mode,
  input  logic [SET_WIDTH-1:0]          i_cmd_value,
  input  logic [DLY_WIDTH-1:0]          i_cmd_delay,
  input  logic [DLY_WIDTH-1:0]          i_cmd_length,
  output logic [SET_SIZE*SET_WIDTH-1:0] o_set_signals,
  output logic [SET_SIZE-1:0]           o_busy,
  output logic [SET_SIZE-1:0]           o_done,
  output logic                          o_cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE} state_t;

  localparam logic [1:0] MODE_SET     = 2'b00;
  localparam logic [1:0] MODE_PULSE   = 2'b01;
  localparam logic [1:0] MODE_RELEASE = 2'b10;
  localparam logic [1:0] MODE_ABORT   = 2'b11;

  logic [31:0] chan_ext;
  logic        in_range;
  logic        busy_sel;

  assign chan_ext = 32'(i_cmd_chan);
  assign in_range = chan_ext < SET_SIZE;

  always_comb begin
    busy_sel = 1'b0;
    for (int k = 0; k < SET_SIZE; k++)
      if (i_cmd_chan == CW'(k)) busy_sel = o_busy[k];
  end

  assign o_cmd_ready = !in_range || (i_cmd_mode == MODE_ABORT) || !busy_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_cmd_err <= 1'b0;
    else     o_cmd_err <= i_cmd_valid && !in_range;
  end

  for (genvar k = 0; k < SET_SIZE; k++) begin : g_chan
    state_t               state;
    logic [DLY_WIDTH-1:0] cnt;
    logic [DLY_WIDTH-1:0] len;
    logic [SET_WIDTH-1:0] val;
    logic [SET_WIDTH-1:0] saved;
    logic [SET_WIDTH-1:0] out;
    logic [1:0]           mode;
    logic                 done;
    logic                 hit;
    logic                 apply;
    logic [SET_WIDTH-1:0] a_val;
    logic [1:0]           a_mode;
    logic [DLY_WIDTH-1:0] a_len;

    assign hit = i_cmd_valid && in_range && (i_cmd_chan == CW'(k));

    // A zero-delay command applies on its own acceptance edge, bypassing WAIT.
    always_comb begin
      apply  = 1'b0;
      a_val  = val;
      a_mode = mode;
      a_len  = len;
      if (state == S_IDLE && hit && i_cmd_mode != MODE_ABORT && i_cmd_delay == '0) begin
        apply  = 1'b1;
        a_val  = i_cmd_value;
        a_mode = i_cmd_mode;
        a_len  = i_cmd_length;
      end else if (state == S_WAIT && cnt == DLY_WIDTH'(1)) begin
        apply = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= S_IDLE;
        cnt   <= '0;
        len   <= '0;
        val   <= '0;
        saved <= '0;
        mode  <= MODE_SET;
        out   <= DEFAULT_VALUE;
        done  <= 1'b0;
      end else begin
        done <= 1'b0;
        if (hit && i_cmd_mode == MODE_ABORT) begin
          if (state == S_PULSE) out <= saved;
          state <= S_IDLE;
          cnt   <= '0;
        end else if (apply) begin
          case (a_mode)
            MODE_PULSE: begin
              saved <= out;
              out   <= a_val;
              state <= S_PULSE;
              cnt   <= (a_len == '0) ? DLY_WIDTH'(1) : a_len;
            end
            MODE_RELEASE: begin
              out   <= DEFAULT_VALUE;
              state <= S_IDLE;
              done  <= 1'b1;
            end
            default: begin
              out   <= a_val;
              state <= S_IDLE;
              done  <= 1'b1;
            end
          endcase
        end else begin
          case (state)
            S_IDLE: if (hit) begin
              val   <= i_cmd_value;
              mode  <= i_cmd_mode;
              len   <= i_cmd_length;
              cnt   <= i_cmd_delay;
              state <= S_WAIT;
            end
            S_WAIT: cnt <= cnt - 1'b1;
            S_PULSE: begin
              if (cnt == DLY_WIDTH'(1)) begin
                out   <= saved;
                state <= S_IDLE;
                done  <= 1'b1;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end

    assign o_set_signals[k*SET_WIDTH +: SET_WIDTH] = out;
    assign o_busy[k] = (state != S_IDLE);
    assign o_done[k] = done;
  end

endmodule

// File: tb/tb_set_injector_seq.sv
// tb/tb_set_injector_seq.sv - directed and random checks against a cycle-time event model
module tb_set_injector_seq;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int DW = 16;
  localparam int CW = 3;
  localparam logic [W-1:0] DEF = 16'h0000;

  localparam logic [1:0] M_SET = 2'b00, M_PULSE = 2'b01, M_REL = 2'b10, M_ABORT = 2'b11;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_cmd_valid = 1'b0;
  logic            o_cmd_ready;
  logic [CW-1:0]   i_cmd_chan = '0;
  logic [1:0]      i_cmd_mode = '0;
  logic [W-1:0]    i_cmd_value = '0;
  logic [DW-1:0]   i_cmd_delay = '0;
  logic [DW-1:0]   i_cmd_length = '0;
  logic [N*W-1:0]  o_set_signals;
  logic [N-1:0]    o_busy;
  logic [N-1:0]    o_done;
  logic            o_cmd_err;

  always #5 clk = ~clk;

  set_injector_seq #(
    .SET_SIZE(N), .SET_WIDTH(W), .DLY_WIDTH(DW), .DEFAULT_VALUE(DEF)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_chan(i_cmd_chan), .i_cmd_mode(i_cmd_mode),
    .i_cmd_value(i_cmd_value), .i_cmd_delay(i_cmd_delay), .i_cmd_length(i_cmd_length),
    .o_set_signals(o_set_signals), .o_busy(o_busy), .o_done(o_done), .o_cmd_err(o_cmd_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each channel holds absolute cycle times for its pending action and pulse end.
  int       t;
  logic [W-1:0] m_out [N];
  logic [W-1:0] m_saved [N];
  logic [W-1:0] m_val [N];
  logic [1:0]   m_mode [N];
  int           m_len [N];
  int           m_apply_t [N];
  int           m_end_t [N];
  bit           m_pend [N];
  bit           m_puls [N];
  bit           m_done [N];
  bit           m_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit mbusy(input int k);
    if (k < 0 || k >= N) return 1'b0;
    return m_pend[k] || m_puls[k];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_out[k] = DEF; m_saved[k] = '0; m_val[k] = '0; m_mode[k] = M_SET;
      m_len[k] = 0; m_apply_t[k] = 0; m_end_t[k] = 0;
      m_pend[k] = 0; m_puls[k] = 0; m_done[k] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_apply(input int k);
    m_pend[k] = 0;
    case (m_mode[k])
      M_SET:   begin m_out[k] = m_val[k]; m_done[k] = 1; end
      M_REL:   begin m_out[k] = DEF; m_done[k] = 1; end
      default: begin
        m_saved[k] = m_out[k];
        m_out[k]   = m_val[k];
        m_puls[k]  = 1;
        m_end_t[k] = t + ((m_len[k] == 0) ? 1 : m_len[k]);
      end
    endcase
  endtask

  task automatic model_step(input bit acc, input int ch, input logic [1:0] md,
                            input logic [W-1:0] val, input int d, input int l);
    m_err = acc && (ch >= N);
    for (int k = 0; k < N; k++) begin
      m_done[k] = 0;
      if (acc && ch == k && md == M_ABORT) begin
        if (m_puls[k]) m_out[k] = m_saved[k];
        m_pend[k] = 0;
        m_puls[k] = 0;
      end else begin
        if (m_pend[k] && t == m_apply_t[k]) model_apply(k);
        else if (m_puls[k] && t == m_end_t[k]) begin
          m_out[k] = m_saved[k]; m_puls[k] = 0; m_done[k] = 1;
        end
        if (acc && ch == k) begin
          m_val[k] = val; m_mode[k] = md; m_len[k] = l;
          m_pend[k] = 1; m_apply_t[k] = t + d;
          if (d == 0) model_apply(k);
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N*W-1:0] es;
    logic [N-1:0]   eb, ed;
    for (int k = 0; k < N; k++) begin
      es[k*W +: W] = m_out[k];
      eb[k] = mbusy(k);
      ed[k] = m_done[k];
    end
    chk({tag, "/set"},  o_set_signals, es);
    chk({tag, "/busy"}, o_busy, eb);
    chk({tag, "/done"}, o_done, ed);
    chk({tag, "/err"},  o_cmd_err, m_err);
  endtask

  task automatic cyc(input string tag, input bit v, input int ch, input logic [1:0] md,
                     input logic [W-1:0] val, input int d, input int l);
    bit exp_ready, acc;
    @(negedge clk);
    check_outputs(tag);
    i_cmd_valid  = v;
    i_cmd_chan   = CW'(ch);
    i_cmd_mode   = md;
    i_cmd_value  = val;
    i_cmd_delay  = DW'(d);
    i_cmd_length = DW'(l);
    #1;
    exp_ready = (ch >= N) || (md == M_ABORT) || !mbusy(ch);
    chk({tag, "/ready"}, o_cmd_ready, exp_ready);
    acc = v && exp_ready;
    @(posedge clk);
    t++;
    model_step(acc, ch, md, val, d, l);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 0, M_SET, '0, 0, 0);
  endtask

  initial begin
    t = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset/set",  o_set_signals, '0);
    chk("reset/busy", o_busy, '0);
    chk("reset/done", o_done, '0);
    chk("reset/err",  o_cmd_err, '0);
    rst = 1'b0;

    idle("warm", 3);
    cyc("set_ch2", 1, 2, M_SET, 16'hA5A5, 0, 0);
    idle("set_ch2_after", 2);

    cyc("set_ch1", 1, 1, M_SET, 16'h1234, 0, 0);
    idle("gap", 1);
    cyc("pulse_ch1", 1, 1, M_PULSE, 16'hFFFF, 3, 4);
    idle("pulse_ch1_run", 9);

    cyc("pulse_ch0", 1, 0, M_PULSE, 16'h5555, 5, 2);
    cyc("refuse_ch0", 1, 0, M_SET, 16'h1111, 0, 0);
    cyc("abort_wait", 1, 0, M_ABORT, 16'h0, 0, 0);
    idle("abort_wait_after", 3);

    cyc("set_ch0_d2", 1, 0, M_SET, 16'h00C3, 2, 0);
    cyc("set_ch3_d1", 1, 3, M_SET, 16'h3C00, 1, 0);
    idle("joint_done", 4);

    cyc("bad_chan", 1, 5, M_SET, 16'hDEAD, 0, 0);
    idle("bad_chan_after", 2);

    cyc("pulse_len0", 1, 2, M_PULSE, 16'h0F0F, 1, 0);
    idle("pulse_len0_run", 4);

    cyc("pulse_ch1_long", 1, 1, M_PULSE, 16'hBEEF, 0, 5);
    idle("pulse_ch1_long_run", 1);
    cyc("abort_pulse", 1, 1, M_ABORT, 16'h0, 0, 0);
    idle("abort_pulse_after", 2);

    cyc("release_ch2", 1, 2, M_REL, 16'h0, 1, 0);
    idle("release_after", 3);

    for (int i = 0; i < 400; i++) begin
      bit          v;
      int          ch, d, l;
      logic [1:0]  md;
      logic [W-1:0] val;
      v   = ($urandom_range(0, 2) != 0);
      ch  = $urandom_range(0, N);
      md  = 2'($urandom_range(0, 3));
      val = W'($urandom);
      d   = $urandom_range(0, 6);
      l   = $urandom_range(0, 5);
      cyc("rand", v, ch, md, val, d, l);
    end
    idle("drain", 20);

    cyc("pulse_ch4", 1, 4, M_PULSE, 16'h7777, 0, 10);
    idle("pulse_ch4_run", 3);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst/set",  o_set_signals, '0);
    chk("async_rst/busy", o_busy, '0);
    chk("async_rst/done", o_done, '0);
    chk("async_rst/err",  o_cmd_err, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc("post_rst_set", 1, 4, M_SET, 16'h0042, 0, 0);
    idle("post_rst_after", 2);

    @(negedge clk);
    check_outputs("final");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
